// File: rtl/swi_conditioner.sv
// Switch-bus conditioner: two-flop synchroniser, per-bit debounce, clean edge pulses and a tick divider.
// Build macro SWI_EDGE_EN: when defined the swi_rise/swi_fall registers exist; otherwise both ports read 0.
module swi_conditioner #(
  parameter int NBITS    = 8,
  parameter int DEBOUNCE = 4,
  parameter int TICK_DIV = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] swi,
  input  logic             tick_en,
  output logic [NBITS-1:0] swi_clean,
  output logic [NBITS-1:0] swi_rise,
  output logic [NBITS-1:0] swi_fall,
  output logic             tick
);

  localparam int DB_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam int TK_W = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

  logic [NBITS-1:0] s1;
  logic [NBITS-1:0] s2;
  logic [NBITS-1:0] flip;
  logic [TK_W-1:0]  tick_cnt_reg;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= swi;
      s2 <= s1;
    end
  end

  // Each bit counts consecutive disagreements; any agreement discards the partial count.
  generate
    for (genvar gi = 0; gi < NBITS; gi++) begin : g_db
      logic [DB_W-1:0] cnt_reg;

      assign flip[gi] = (s2[gi] != swi_clean[gi]) && (cnt_reg == DB_LAST);

      always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if ((s2[gi] == swi_clean[gi]) || flip[gi]) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + DB_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      swi_clean <= '0;
    end else begin
      swi_clean <= swi_clean ^ flip;
    end
  end

`ifdef SWI_EDGE_EN
  // Pulses are registered on the same edge that updates swi_clean.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      swi_rise <= '0;
      swi_fall <= '0;
    end else begin
      swi_rise <= flip & ~swi_clean;
      swi_fall <= flip & swi_clean;
    end
  end
`else
  assign swi_rise = '0;
  assign swi_fall = '0;
`endif

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      tick_cnt_reg <= '0;
      tick         <= 1'b0;
    end else if (tick_en) begin
      tick         <= (tick_cnt_reg == TK_LAST);
      tick_cnt_reg <= (tick_cnt_reg == TK_LAST) ? '0 : tick_cnt_reg + TK_W'(1);
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_swi_conditioner.sv
// Bench for swi_conditioner: vector table, directed corner sequences, and randomized run against a window-based model.
`timescale 1ns/1ps
module tb_swi_conditioner;
  localparam int NBITS    = 8;
  localparam int DEBOUNCE = 4;
  localparam int TICK_DIV = 4;
`ifdef SWI_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic             clk_2 = 1'b0;
  logic             reset = 1'b1;
  logic [NBITS-1:0] swi = '0;
  logic             tick_en = 1'b0;
  logic [NBITS-1:0] swi_clean, swi_rise, swi_fall;
  logic             tick;

  swi_conditioner #(.NBITS(NBITS), .DEBOUNCE(DEBOUNCE), .TICK_DIV(TICK_DIV)) dut (
    .clk_2(clk_2), .reset(reset), .swi(swi), .tick_en(tick_en),
    .swi_clean(swi_clean), .swi_rise(swi_rise), .swi_fall(swi_fall), .tick(tick)
  );

  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int errors = 0;

  // Reference model: a bit flips once the last DEBOUNCE synchronised samples all disagree with it.
  logic [NBITS-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
  logic             m_tick;
  int               en_count;
  logic [NBITS-1:0] win[$];

  typedef struct {
    logic [NBITS-1:0] swi;
    logic             en;
    logic [NBITS-1:0] clean;
    logic [NBITS-1:0] rise;
    logic             tick;
  } vec_t;
  vec_t vec[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
    m_tick = 1'b0; en_count = 0;
    win.delete();
  endtask

  task automatic model_edge();
    logic [NBITS-1:0] seen, old;
    logic all_diff;
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = swi;
    win.push_back(seen);
    if (win.size() > DEBOUNCE) void'(win.pop_front());
    old = m_clean;
    for (int i = 0; i < NBITS; i++) begin
      all_diff = (win.size() == DEBOUNCE);
      foreach (win[j]) if (win[j][i] == old[i]) all_diff = 1'b0;
      if (all_diff) m_clean[i] = ~old[i];
    end
    m_rise = (m_clean & ~old) & {NBITS{EDGE}};
    m_fall = (old & ~m_clean) & {NBITS{EDGE}};
    if (tick_en) begin
      en_count++;
      m_tick = ((en_count % TICK_DIV) == 0);
    end else begin
      m_tick = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    if (reset) model_reset(); else model_edge();
    #1;
    check("swi_clean", 32'(swi_clean), 32'(m_clean));
    check("swi_rise",  32'(swi_rise),  32'(m_rise));
    check("swi_fall",  32'(swi_fall),  32'(m_fall));
    check("tick",      32'(tick),      32'(m_tick));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int f1, r4, got, last_rise3, last_clean3;
    // Clean step 0x00 -> 0x05 with tick enabled; row i is applied before edge i+1 after reset release.
    vec[0]  = '{8'h05, 1'b1, 8'h00, 8'h00, 1'b0};
    vec[1]  = '{8'h05, 1'b1, 8'h00, 8'h00, 1'b0};
    vec[2]  = '{8'h05, 1'b1, 8'h00, 8'h00, 1'b0};
    vec[3]  = '{8'h05, 1'b1, 8'h00, 8'h00, 1'b1};
    vec[4]  = '{8'h05, 1'b1, 8'h00, 8'h00, 1'b0};
    vec[5]  = '{8'h05, 1'b1, 8'h05, 8'h05, 1'b0};
    vec[6]  = '{8'h05, 1'b1, 8'h05, 8'h00, 1'b0};
    vec[7]  = '{8'h05, 1'b1, 8'h05, 8'h00, 1'b1};
    vec[8]  = '{8'h05, 1'b1, 8'h05, 8'h00, 1'b0};
    vec[9]  = '{8'h05, 1'b1, 8'h05, 8'h00, 1'b0};
    vec[10] = '{8'h05, 1'b1, 8'h05, 8'h00, 1'b0};
    vec[11] = '{8'h05, 1'b1, 8'h05, 8'h00, 1'b1};
    vec[12] = '{8'h05, 1'b1, 8'h05, 8'h00, 1'b0};

    model_reset();
    repeat (2) step();
    $display("reset: clean=0x%0h rise=0x%0h fall=0x%0h tick=%0b", swi_clean, swi_rise, swi_fall, tick);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      swi = vec[i].swi;
      tick_en = vec[i].en;
      step();
      check("vec_clean", 32'(swi_clean), 32'(vec[i].clean));
      check("vec_rise",  32'(swi_rise),  32'(vec[i].rise & {NBITS{EDGE}}));
      check("vec_fall",  32'(swi_fall),  32'h0);
      check("vec_tick",  32'(tick),      32'(vec[i].tick));
      $display("vec %0d: swi=0x%0h clean=0x%0h rise=0x%0h fall=0x%0h tick=%0b",
               i, swi, swi_clean, swi_rise, swi_fall, tick);
    end

    // Glitch on bit 3 shorter than the debounce window.
    last_rise3 = 0; last_clean3 = 0;
    swi = 8'h0D;
    repeat (3) begin
      step();
      last_rise3 |= int'(swi_rise[3]); last_clean3 |= int'(swi_clean[3]);
    end
    swi = 8'h05;
    repeat (8) begin
      step();
      last_rise3 |= int'(swi_rise[3]); last_clean3 |= int'(swi_clean[3]);
    end
    check("glitch_clean3", 32'(last_clean3), 32'h0);
    check("glitch_rise3",  32'(last_rise3),  32'h0);
    $display("glitch: clean=0x%0h", swi_clean);

    // Multi-bit: bit1 falls and bit4 rises from the same input change.
    swi = 8'h02;
    repeat (8) step();
    check("multi_pre", 32'(swi_clean), 32'h02);
    swi = 8'h10;
    f1 = -1; r4 = -1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (f1 < 0 && !swi_clean[1]) begin
        f1 = n;
        check("multi_fall1", 32'(swi_fall[1]), 32'(EDGE));
      end
      if (r4 < 0 && swi_clean[4]) begin
        r4 = n;
        check("multi_rise4", 32'(swi_rise[4]), 32'(EDGE));
      end
    end
    check("multi_same_cycle", 32'(f1), 32'(r4));
    check("multi_latency", 32'(f1), 32'(DEBOUNCE + 2));
    $display("multi: fall1 at %0d rise4 at %0d clean=0x%0h", f1, r4, swi_clean);

    // Asynchronous reset two cycles into a debounce of bit 0.
    swi = 8'h11;
    step(); step();
    #2 reset = 1'b1;
    #1;
    check("async_clean", 32'(swi_clean), 32'h0);
    check("async_rise",  32'(swi_rise),  32'h0);
    check("async_fall",  32'(swi_fall),  32'h0);
    check("async_tick",  32'(tick),      32'h0);
    model_reset();
    step();
    reset = 1'b0;
    got = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (got < 0 && swi_clean[0]) begin
        got = n;
        check("rel_rise0", 32'(swi_rise[0]), 32'(EDGE));
      end
    end
    check("rel_latency", 32'(got), 32'(DEBOUNCE + 2));
    $display("reset mid-debounce: clean[0] set %0d edges after release", got);

    // Tick divider: hold phase across a disable window.
    reset = 1'b1;
    step();
    reset = 1'b0;
    tick_en = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      step();
      check("tick_run", 32'(tick), 32'((n % TICK_DIV) == 0));
    end
    tick_en = 1'b0;
    repeat (5) begin
      step();
      check("tick_hold", 32'(tick), 32'h0);
    end
    tick_en = 1'b1;
    got = -1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (got < 0 && tick) got = n;
    end
    check("tick_resume", 32'(got), 32'(TICK_DIV - 1));
    $display("tick: resumed tick after %0d enabled cycles", got);

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0: swi = NBITS'($urandom);
        1: swi[$urandom_range(0, NBITS - 1)] ^= 1'b1;
        default: ;
      endcase
      tick_en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        #2;
        model_reset();
        check("rnd_rst_clean", 32'(swi_clean), 32'h0);
        check("rnd_rst_tick",  32'(tick),      32'h0);
        reset = 1'b0;
      end
      step();
    end
    $display("random: 600 cycles done, clean=0x%0h", swi_clean);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
